// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - i/j/k sequencer and accumulator feeding the signed MAC unit of the NxN matrix multiplier.
module matmul_sequencer #(
    parameter int Width = 8,
    parameter int N     = 4,
    parameter int IW    = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              op_in,
    output logic [2*IW-1:0]   a_addr,
    input  logic [Width-1:0]  a_data,
    output logic [2*IW-1:0]   b_addr,
    input  logic [Width-1:0]  b_data,
    output logic [Width-1:0]  au_a,
    output logic [Width-1:0]  au_b,
    output logic [Width-1:0]  au_c,
    output logic              au_op,
    output logic              au_reset,
    input  logic [Width-1:0]  au_out,
    input  logic              au_error,
    output logic              c_we,
    output logic [2*IW-1:0]   c_addr,
    output logic [Width-1:0]  c_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_t            state, state_nxt;
    logic [IW-1:0]     i_q, j_q, k_q;
    logic [IW-1:0]     i_nxt, j_nxt, k_nxt;
    logic [Width-1:0]  acc_q, acc_nxt;
    logic              op_q, op_nxt;
    logic              err_q, err_nxt;

    logic              last_i, last_j, last_k;

    assign last_i = (i_q == LAST);
    assign last_j = (j_q == LAST);
    assign last_k = (k_q == LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            op_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            i_q   <= i_nxt;
            j_q   <= j_nxt;
            k_q   <= k_nxt;
            acc_q <= acc_nxt;
            op_q  <= op_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i_q;
        j_nxt     = j_q;
        k_nxt     = k_q;
        acc_nxt   = acc_q;
        op_nxt    = op_q;
        err_nxt   = err_q;
        c_we      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt    = op_in;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                    acc_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                err_nxt = err_q | au_error;
                if (!last_k) begin
                    acc_nxt = au_out;
                    k_nxt   = k_q + ONE;
                end else begin
                    // Element finished: the unit's combinational result goes straight to C.
                    c_we    = 1'b1;
                    acc_nxt = '0;
                    k_nxt   = '0;
                    j_nxt   = j_q + ONE;
                    if (last_j) begin
                        i_nxt = i_q + ONE;
                    end
                    if (last_i && last_j) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                err_nxt   = err_q | au_error;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign a_addr   = {i_q, k_q};
    assign b_addr   = {k_q, j_q};
    assign c_addr   = {i_q, j_q};
    assign c_wdata  = au_out;

    assign au_a     = a_data;
    assign au_b     = b_data;
    assign au_c     = acc_q;
    assign au_op    = op_q;
    // Clearing the unit on the accepting cycle drops any Error left over from the previous run.
    assign au_reset = reset | ((state == IDLE) & start);

    assign busy     = (state == MAC);
    assign done     = (state == DONE);
    // The unit's Error is registered, so the final MAC step's overflow only shows up during DONE.
    assign err      = err_q | (done & au_error);

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer with a behavioural MAC unit and register files.
module tb_matmul_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        op_in;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic [7:0]  a_data, b_data;
    logic [7:0]  au_a, au_b, au_c, au_out, c_wdata;
    logic        au_op, au_reset, au_error, c_we, busy, done, err;

    always #5 CLK = ~CLK;

    matmul_sequencer dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .op_in    (op_in),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .au_a     (au_a),
        .au_b     (au_b),
        .au_c     (au_c),
        .au_op    (au_op),
        .au_reset (au_reset),
        .au_out   (au_out),
        .au_error (au_error),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    logic [7:0] amem [16];
    logic [7:0] bmem [16];
    assign a_data = amem[a_addr];
    assign b_data = bmem[b_addr];

    // Arithmetic unit: Out = C +/- A*B wrapped to 8 bits; Error registered and sticky until reset.
    int   full;
    logic ovf;
    always_comb begin
        full   = int'($signed(au_c)) + (au_op ? -1 : 1) * int'($signed(au_a)) * int'($signed(au_b));
        au_out = full[7:0];
        ovf    = (full > 127) || (full < -128);
    end
    always_ff @(posedge CLK) begin
        if (au_reset)  au_error <= 1'b0;
        else if (ovf)  au_error <= 1'b1;
    end

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        int am;
        int bm;
        bit op;
        bit exp_err;
    } vec_t;
    vec_t vecs[6];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (c_we) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("c_addr", int'(c_addr), int'(e.addr));
                check("c_wdata", int'(c_wdata), int'(e.data));
            end
        end
        if (done) done_cnt++;
    end

    function automatic logic [7:0] val(input int mode, input int r, input int c);
        case (mode)
            0:       return (r == c) ? 8'd1 : 8'd0;
            1:       return 8'd1;
            2:       return 8'd2;
            3:       return 8'(r * 4 + c);
            4:       return 8'd127;
            default: return 8'd0;
        endcase
    endfunction

    task automatic load(input int am, input int bm);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                amem[r*4+c] = val(am, r, c);
                bmem[r*4+c] = val(bm, r, c);
            end
    endtask

    task automatic push_expected(input bit op);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int  s;
                wr_t e;
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += int'($signed(amem[i*4+k])) * int'($signed(bmem[k*4+j]));
                if (op) s = -s;
                e.addr = 4'(i * 4 + j);
                e.data = 8'(s);
                sb.push_back(e);
            end
    endtask

    // Starts a run on the next edge and follows it to done; cycle 1 is the first MAC cycle.
    task automatic run(input bit op, output int done_at, output bit err_at);
        int busy_cnt;
        busy_cnt = 0;
        done_at  = -1;
        err_at   = 1'b0;
        wr_cnt   = 0;
        @(negedge CLK);
        start = 1'b1;
        op_in = op;
        @(negedge CLK);
        start = 1'b0;
        op_in = ~op;
        for (int c = 1; c <= 80; c++) begin
            if (c <= 4) begin
                check("a_addr_trace", int'(a_addr), c - 1);
                check("b_addr_trace", int'(b_addr), (c - 1) * 4);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_at = c;
                err_at  = err;
                break;
            end
            @(negedge CLK);
        end
        check("done_cycle", done_at, 65);
        check("busy_cycles", busy_cnt, 64);
        check("write_count", wr_cnt, 16);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int done_at;
        bit err_at;

        vecs[0] = '{am: 0, bm: 3, op: 1'b0, exp_err: 1'b0};
        vecs[1] = '{am: 1, bm: 2, op: 1'b0, exp_err: 1'b0};
        vecs[2] = '{am: 1, bm: 2, op: 1'b1, exp_err: 1'b0};
        vecs[3] = '{am: 4, bm: 4, op: 1'b0, exp_err: 1'b1};
        vecs[4] = '{am: 5, bm: 5, op: 1'b0, exp_err: 1'b0};
        vecs[5] = '{am: 3, bm: 3, op: 1'b1, exp_err: 1'b1};

        reset = 1'b1;
        start = 1'b0;
        op_in = 1'b0;
        load(5, 5);
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_c_we", c_we, 0);
        check("reset_err", err, 0);
        check("reset_a_addr", int'(a_addr), 0);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].am, vecs[v].bm);
            push_expected(vecs[v].op);
            run(vecs[v].op, done_at, err_at);
            check($sformatf("err_at_done_v%0d", v), err_at, vecs[v].exp_err);
            @(negedge CLK);
            check($sformatf("err_hold_v%0d", v), err, vecs[v].exp_err);
            check($sformatf("idle_after_v%0d", v), busy | done, 0);
        end

        // start re-pulsed during MAC and DONE must be ignored.
        load(0, 3);
        push_expected(1'b0);
        wr_cnt   = 0;
        done_cnt = 0;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        for (int c = 1; c <= 70; c++) begin
            start = (c == 10 || c == 64 || c == 65);
            @(negedge CLK);
        end
        start = 1'b0;
        check("restart_writes", wr_cnt, 16);
        check("restart_dones", done_cnt, 1);
        check("restart_idle", busy, 0);
        check("restart_sb", sb.size(), 0);

        // Reset in the middle of a run, then a clean run and a back-to-back one.
        load(1, 2);
        push_expected(1'b0);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (19) @(negedge CLK);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_c_we", c_we, 0);
        check("mid_reset_done", done, 0);
        sb.delete();

        load(0, 3);
        push_expected(1'b0);
        run(1'b0, done_at, err_at);
        check("post_reset_err", err_at, 0);
        load(1, 2);
        push_expected(1'b1);
        run(1'b1, done_at, err_at);
        check("b2b_err", err_at, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
